router_slice_olck_arbiter: RTL and testbench

ROUTER_SLICE_OLCK_ARBITER -- requirements
Module: router_slice_olck_arbiter

---
 rtl/router_slice_arb_pkg.sv | 18 +
 rtl/rr_priority_pick.sv | 32 +++
 rtl/router_slice_olck_arbiter.sv | 108 ++++++++++
 tb/tb_router_slice_olck_arbiter.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/router_slice_arb_pkg.sv
// Shared types and default constants for the router slice output-latch arbiter.
// Contents:
//   arb_state_e     - arbiter FSM state (IDLE, HOLD)
//   DEF_NUM_REQ     - default number of requesters
//   DEF_DATA_W      - default output-latch bank width
//   DEF_HOLD_CYCLES - default number of cycles a granted word is held
package router_slice_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } arb_state_e;

    localparam int DEF_NUM_REQ     = 4;
    localparam int DEF_DATA_W      = 4;
    localparam int DEF_HOLD_CYCLES = 2;

endpackage

// File: rtl/rr_priority_pick.sv
// Combinational round-robin picker.
// Ports:
//   req        in  NUM_REQ  request vector
//   last_grant in  IDX_W    index granted most recently
//   grant      out NUM_REQ  one-hot grant (zero when req is zero)
// The search starts at (last_grant+1) mod NUM_REQ and walks upward with wrap-around.
module rr_priority_pick #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   last_grant,
    output logic [NUM_REQ-1:0] grant
);

    logic             found;
    logic [IDX_W-1:0] idx;

    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = IDX_W'((int'(last_grant) + k) % NUM_REQ);
            if (!found && req[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/router_slice_olck_arbiter.sv
// Round-robin arbiter feeding a shared output-latch (ff_OLCK) register bank.
// A winner's word is latched and held for HOLD_CYCLES cycles, followed by at
// least one IDLE cycle before the next grant.
// Ports:
//   clk        in  1               clock
//   reset      in  1               synchronous active-high reset
//   req_valid  in  NUM_REQ         per-requester valid
//   req_data   in  NUM_REQ*DATA_W  per-requester word, requester i at [i*DATA_W +: DATA_W]
//   req_ready  out NUM_REQ         one-hot grant, only in IDLE
//   flush      in  1               abort current hold / suppress grant
//   olck_d     out DATA_W          word driven to the latch bank
//   olck_valid out 1               olck_d carries a granted word
//   olck_owner out IDX_W           requester owning olck_d
//   busy       out 1               FSM not in IDLE
//
// state | meaning
// IDLE  | waiting for a request; req_ready may be asserted combinationally
// HOLD  | granted word held on the bank while hold_cnt counts down to 0
module router_slice_olck_arbiter
    import router_slice_arb_pkg::*;
#(
    parameter int NUM_REQ     = DEF_NUM_REQ,
    parameter int DATA_W      = DEF_DATA_W,
    parameter int HOLD_CYCLES = DEF_HOLD_CYCLES
) (
    input  logic                                          clk,
    input  logic                                          reset,
    input  logic [NUM_REQ-1:0]                            req_valid,
    input  logic [NUM_REQ*DATA_W-1:0]                     req_data,
    output logic [NUM_REQ-1:0]                            req_ready,
    input  logic                                          flush,
    output logic [DATA_W-1:0]                             olck_d,
    output logic                                          olck_valid,
    output logic [((NUM_REQ > 1) ? $clog2(NUM_REQ) : 1)-1:0] olck_owner,
    output logic                                          busy
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = 4;

    arb_state_e         state;
    logic [CNT_W-1:0]   hold_cnt;
    logic [IDX_W-1:0]   last_grant;
    logic [NUM_REQ-1:0] grant;
    logic [IDX_W-1:0]   winner;
    logic [DATA_W-1:0]  win_data;
    logic               transfer;

    rr_priority_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_pick (
        .req        (req_valid),
        .last_grant (last_grant),
        .grant      (grant)
    );

    always_comb begin
        winner   = '0;
        win_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                winner   = IDX_W'(i);
                win_data = req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    // Grant only in IDLE; reset and flush both mask it in the same cycle.
    assign req_ready = (state == IDLE && !reset && !flush) ? grant : '0;
    assign transfer  = |(req_valid & req_ready);
    assign busy      = (state == HOLD);

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            olck_valid <= 1'b0;
            olck_d     <= '0;
            olck_owner <= '0;
            hold_cnt   <= '0;
            last_grant <= IDX_W'(NUM_REQ - 1);
        end else begin
            case (state)
                IDLE: begin
                    if (transfer) begin
                        olck_d     <= win_data;
                        olck_owner <= winner;
                        olck_valid <= 1'b1;
                        hold_cnt   <= CNT_W'(HOLD_CYCLES - 1);
                        last_grant <= winner;
                        state      <= HOLD;
                    end
                end
                HOLD: begin
                    if (flush || hold_cnt == '0) begin
                        state      <= IDLE;
                        olck_valid <= 1'b0;
                        hold_cnt   <= '0;
                    end else begin
                        hold_cnt <= hold_cnt - CNT_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_router_slice_olck_arbiter.sv
module tb_router_slice_olck_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        flush = 1'b0;
    logic [3:0]  req_valid = '0;
    logic [15:0] req_data = '0;

    logic [3:0]  req_ready,  req_ready4;
    logic [3:0]  olck_d,     olck_d4;
    logic        olck_valid, olck_valid4;
    logic [1:0]  olck_owner, olck_owner4;
    logic        busy,       busy4;

    always #5 clk = ~clk;

    router_slice_olck_arbiter #(.NUM_REQ(4), .DATA_W(4), .HOLD_CYCLES(2)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_data(req_data),
        .req_ready(req_ready), .flush(flush), .olck_d(olck_d),
        .olck_valid(olck_valid), .olck_owner(olck_owner), .busy(busy));

    router_slice_olck_arbiter #(.NUM_REQ(4), .DATA_W(4), .HOLD_CYCLES(4)) dut4 (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_data(req_data),
        .req_ready(req_ready4), .flush(flush), .olck_d(olck_d4),
        .olck_valid(olck_valid4), .olck_owner(olck_owner4), .busy(busy4));

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model: 'left' is the number of valid cycles still to come,
    // including the current one.
    typedef struct {
        bit       valid;
        int       left;
        int       last;
        int       owner;
        bit [3:0] d;
    } mdl_t;

    mdl_t m2, m4;
    bit       prev_v2, prev_v4;
    bit [3:0] prev_d2, prev_d4;

    function automatic mdl_t m_reset();
        mdl_t s;
        s.valid = 0; s.left = 0; s.last = 3; s.owner = 0; s.d = '0;
        return s;
    endfunction

    function automatic bit [3:0] m_ready(mdl_t s, bit [3:0] v, bit f, bit r);
        bit [3:0] g = '0;
        if (r || f || s.valid) return g;
        for (int k = 1; k <= 4; k++) begin
            if (v[(s.last + k) % 4]) begin
                g[(s.last + k) % 4] = 1'b1;
                return g;
            end
        end
        return g;
    endfunction

    function automatic mdl_t m_next(mdl_t s, bit [3:0] v, bit [15:0] dat, bit f, bit r, int hc);
        mdl_t n = s;
        bit [3:0] g;
        if (r) return m_reset();
        if (s.valid) begin
            if (f || s.left == 1) begin n.valid = 0; n.left = 0; end
            else n.left = s.left - 1;
        end else begin
            g = m_ready(s, v, f, r);
            for (int i = 0; i < 4; i++) begin
                if (g[i]) begin
                    n.valid = 1; n.left = hc; n.last = i; n.owner = i;
                    n.d = 4'((dat >> (4 * i)) & 16'hF);
                end
            end
        end
        return n;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // One clock cycle: drive, check combinational grant, clock, check registers.
    task automatic step(input bit r, input bit f, input bit [3:0] v, input bit [15:0] dat);
        reset = r; flush = f; req_valid = v; req_data = dat;
        #1;
        chk("ready_h2", 32'(req_ready),  32'(m_ready(m2, v, f, r)));
        chk("ready_h4", 32'(req_ready4), 32'(m_ready(m4, v, f, r)));
        chk("ready_onehot_h2", 32'($onehot0(req_ready)), 32'd1);
        chk("ready_onehot_h4", 32'($onehot0(req_ready4)), 32'd1);
        chk("ready_in_hold_h2", 32'(req_ready != 0 && busy  === 1'b1), 32'd0);
        chk("ready_in_hold_h4", 32'(req_ready4 != 0 && busy4 === 1'b1), 32'd0);
        @(posedge clk);
        m2 = m_next(m2, v, dat, f, r, 2);
        m4 = m_next(m4, v, dat, f, r, 4);
        #1;
        chk("valid_h2", 32'(olck_valid), 32'(m2.valid));
        chk("busy_h2",  32'(busy),       32'(m2.valid));
        chk("owner_h2", 32'(olck_owner), 32'(m2.owner));
        chk("d_h2",     32'(olck_d),     32'(m2.d));
        chk("valid_h4", 32'(olck_valid4), 32'(m4.valid));
        chk("busy_h4",  32'(busy4),       32'(m4.valid));
        chk("owner_h4", 32'(olck_owner4), 32'(m4.owner));
        chk("d_h4",     32'(olck_d4),     32'(m4.d));
        if (prev_v2 && olck_valid)  chk("d_stable_h2", 32'(olck_d),  32'(prev_d2));
        if (prev_v4 && olck_valid4) chk("d_stable_h4", 32'(olck_d4), 32'(prev_d4));
        prev_v2 = olck_valid;  prev_d2 = olck_d;
        prev_v4 = olck_valid4; prev_d4 = olck_d4;
    endtask

    typedef struct {
        bit        rst;
        bit        fl;
        bit [3:0]  vld;
        bit [15:0] dat;
        bit [3:0]  exp_rdy;
        bit        exp_v;
        bit [1:0]  exp_o;
        bit [3:0]  exp_d;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(bit r, bit f, bit [3:0] v, bit [15:0] d,
                                bit [3:0] er, bit ev, bit [1:0] eo, bit [3:0] ed);
        vec_t t;
        t.rst = r; t.fl = f; t.vld = v; t.dat = d;
        t.exp_rdy = er; t.exp_v = ev; t.exp_o = eo; t.exp_d = ed;
        return t;
    endfunction

    localparam bit [15:0] D = 16'h4321;

    initial begin
        int run;
        m2 = m_reset(); m4 = m_reset();
        prev_v2 = 0; prev_v4 = 0; prev_d2 = '0; prev_d4 = '0;

        // Expectations below are for the HOLD_CYCLES=2 instance.
        tbl.push_back(mk(1,0,4'hF,D,       4'h0,0,0,4'h0)); // reset masks ready
        tbl.push_back(mk(0,0,4'h1,16'h000A,4'h1,1,0,4'hA)); // single request
        tbl.push_back(mk(0,0,4'h1,16'h000A,4'h0,1,0,4'hA));
        tbl.push_back(mk(0,0,4'h0,D,       4'h0,0,0,4'hA)); // olck_d retained
        tbl.push_back(mk(0,0,4'hF,D,       4'h2,1,1,4'h2)); // all requesting
        tbl.push_back(mk(0,0,4'hF,D,       4'h0,1,1,4'h2));
        tbl.push_back(mk(0,0,4'hF,D,       4'h0,0,1,4'h2));
        tbl.push_back(mk(0,0,4'hF,D,       4'h4,1,2,4'h3));
        tbl.push_back(mk(0,0,4'hF,D,       4'h0,1,2,4'h3));
        tbl.push_back(mk(0,0,4'hF,D,       4'h0,0,2,4'h3));
        tbl.push_back(mk(0,0,4'hF,D,       4'h8,1,3,4'h4));
        tbl.push_back(mk(0,0,4'hF,D,       4'h0,1,3,4'h4));
        tbl.push_back(mk(0,0,4'hF,D,       4'h0,0,3,4'h4));
        tbl.push_back(mk(0,0,4'hF,D,       4'h1,1,0,4'h1)); // wrap to 0
        tbl.push_back(mk(0,0,4'hF,D,       4'h0,1,0,4'h1));
        tbl.push_back(mk(0,0,4'hF,D,       4'h0,0,0,4'h1));
        tbl.push_back(mk(0,0,4'h2,D,       4'h2,1,1,4'h2)); // last_grant := 1
        tbl.push_back(mk(0,0,4'h3,D,       4'h0,1,1,4'h2));
        tbl.push_back(mk(0,0,4'h3,D,       4'h0,0,1,4'h2));
        tbl.push_back(mk(0,0,4'h3,D,       4'h1,1,0,4'h1)); // skips requester 1
        tbl.push_back(mk(0,0,4'h0,D,       4'h0,1,0,4'h1));
        tbl.push_back(mk(0,0,4'h0,D,       4'h0,0,0,4'h1));
        tbl.push_back(mk(0,1,4'h4,D,       4'h0,0,0,4'h1)); // flush in IDLE
        tbl.push_back(mk(0,0,4'h2,D,       4'h2,1,1,4'h2)); // last_grant unchanged
        tbl.push_back(mk(0,1,4'h0,D,       4'h0,0,1,4'h2)); // flush first HOLD cycle
        tbl.push_back(mk(0,0,4'hF,D,       4'h4,1,2,4'h3)); // continues from owner 1
        tbl.push_back(mk(0,0,4'h0,D,       4'h0,1,2,4'h3));
        tbl.push_back(mk(0,0,4'h0,D,       4'h0,0,2,4'h3));
        tbl.push_back(mk(1,1,4'hF,D,       4'h0,0,0,4'h0)); // reset+flush = reset
        tbl.push_back(mk(0,0,4'hF,D,       4'h1,1,0,4'h1));
        tbl.push_back(mk(1,0,4'hF,D,       4'h0,0,0,4'h0)); // reset mid-HOLD
        tbl.push_back(mk(0,0,4'h8,D,       4'h8,1,3,4'h4));
        tbl.push_back(mk(0,0,4'h0,D,       4'h0,1,3,4'h4));
        tbl.push_back(mk(0,0,4'h0,D,       4'h0,0,3,4'h4));
        tbl.push_back(mk(1,0,4'h0,D,       4'h0,0,0,4'h0));
        tbl.push_back(mk(0,0,4'h9,D,       4'h1,1,0,4'h1));
        tbl.push_back(mk(0,0,4'h0,D,       4'h0,1,0,4'h1));
        tbl.push_back(mk(0,0,4'h0,D,       4'h0,0,0,4'h1));

        @(posedge clk); #1;
        foreach (tbl[i]) begin
            reset = tbl[i].rst; flush = tbl[i].fl;
            req_valid = tbl[i].vld; req_data = tbl[i].dat;
            #1;
            chk($sformatf("tbl%0d_ready", i), 32'(req_ready), 32'(tbl[i].exp_rdy));
            step(tbl[i].rst, tbl[i].fl, tbl[i].vld, tbl[i].dat);
            chk($sformatf("tbl%0d_valid", i), 32'(olck_valid), 32'(tbl[i].exp_v));
            chk($sformatf("tbl%0d_owner", i), 32'(olck_owner), 32'(tbl[i].exp_o));
            chk($sformatf("tbl%0d_d", i),     32'(olck_d),     32'(tbl[i].exp_d));
        end

        // Flush on first HOLD cycle with a 4-cycle hold: valid lasts one cycle.
        step(1, 0, 4'h0, D);
        step(0, 0, 4'h1, 16'h000A);
        chk("flush4_valid_first", 32'(olck_valid4), 32'd1);
        run = 1;
        step(0, 1, 4'h0, D);
        if (olck_valid4) run++;
        chk("flush4_valid_len", 32'(run), 32'd1);
        reset = 0; flush = 0; req_valid = 4'hF; req_data = D;
        #1;
        chk("flush4_next_rr", 32'(req_ready4), 32'h2);
        step(0, 0, 4'hF, D);
        chk("flush4_next_owner", 32'(olck_owner4), 32'd1);
        for (int i = 0; i < 6; i++) step(0, 0, 4'h0, D);

        // Full 4-cycle hold length.
        step(0, 0, 4'h4, D);
        run = 0;
        for (int i = 0; i < 8; i++) begin
            if (olck_valid4) run++;
            step(0, 0, 4'h0, D);
        end
        chk("hold4_len", 32'(run), 32'd4);

        // Request withdrawn before the edge: no transfer, last_grant untouched.
        step(1, 0, 4'h0, D);
        reset = 0; flush = 0; req_valid = 4'h4; req_data = D;
        #1;
        chk("drop_pre_ready", 32'(req_ready), 32'h4);
        step(0, 0, 4'h0, D);
        chk("drop_no_xfer", 32'(olck_valid), 32'd0);
        reset = 0; flush = 0; req_valid = 4'hC; req_data = D;
        #1;
        chk("drop_last_kept", 32'(req_ready), 32'h4);
        step(0, 0, 4'hC, D);
        step(0, 0, 4'h0, D);
        step(0, 0, 4'h0, D);

        // Randomized traffic against the reference model.
        for (int i = 0; i < 600; i++) begin
            step($urandom_range(0, 31) == 0, $urandom_range(0, 7) == 0,
                 4'($urandom), 16'($urandom));
        end

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule
